// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: framing constants, receiver state and
// link-speed encodings, and a byte-wide reflected CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        SPEED_10  = 2'b00,
        SPEED_100 = 2'b01,
        SPEED_1G  = 2'b10
    } eth_speed_t;

    // One byte of the LSB-first CRC-32; no final inversion, so running it
    // over a frame plus its FCS leaves ETH_CRC_RESIDUE.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rgmii_rx_framer_if.sv
// Frame word stream from the RX framer towards the downstream RX FIFO.
// There is no ready signal: the FIFO must accept every strobed word.
interface rgmii_rx_framer_if #(
    parameter int OUT_BYTES = 4
);
    logic [8*OUT_BYTES-1:0] m_data;
    logic [OUT_BYTES-1:0]   m_keep;
    logic                   m_valid;
    logic                   m_last;
    logic                   m_err;

    modport master (output m_data, m_keep, m_valid, m_last, m_err);
    modport slave  (input  m_data, m_keep, m_valid, m_last, m_err);
endinterface

// File: rtl/rgmii_rx_nibble_pack.sv
// Turns the captured RGMII byte lane into a byte strobe. At 1G every valid
// cycle carries a whole byte; at 10/100 only the low nibble is meaningful
// and two consecutive nibbles (low first) make one byte.
module rgmii_rx_nibble_pack
    import eth_pkg::*;
(
    input  logic       clk_125,
    input  logic       rst,
    input  logic [7:0] rx_data_i,
    input  logic       rx_dv_i,
    input  eth_speed_t speed_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       odd_nibble_o
);

    logic       phase_q;
    logic [3:0] lowNib_q;

    // Nibble phase restarts on every rx_dv rising edge; the low nibble is parked until its partner arrives.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            phase_q  <= 1'b0;
            lowNib_q <= 4'h0;
        end else if (!rx_dv_i || speed_i == SPEED_1G) begin
            phase_q  <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                lowNib_q <= rx_data_i[3:0];
            end
        end
    end

    // A pending low nibble at end of frame is reported as an odd nibble.
    always_comb begin
        byte_o       = rx_data_i;
        byte_stb_o   = rx_dv_i;
        odd_nibble_o = 1'b0;
        if (speed_i != SPEED_1G) begin
            byte_o       = {rx_data_i[3:0], lowNib_q};
            byte_stb_o   = rx_dv_i & phase_q;
            odd_nibble_o = phase_q;
        end
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII RX framer (clk_125 domain): strips preamble/SFD, packs frame bytes
// into OUT_BYTES-wide words, flags bad frames and keeps good/bad counters.
// Optional feature: define ETH_RX_FCS_CHECK_EN to check the CRC-32 residue
// at end of frame; without it err comes from rx_er, runt, giant or odd nibble.
module rgmii_rx_framer
    import eth_pkg::*;
#(
    parameter int OUT_BYTES     = 4,
    parameter int MIN_PREAMBLE  = 1,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int CNT_W         = 32
) (
    input  logic             clk_125,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_dv,
    input  logic             rx_er,
    rgmii_rx_framer_if.master m,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             full_duplex,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_bad
);

    localparam int FILL_W = $clog2(OUT_BYTES + 1);
    localparam int BCNT_W = $clog2(MAX_FRAME_LEN + 2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(OUT_BYTES);
    localparam logic [BCNT_W-1:0] MAX_CNT   = BCNT_W'(MAX_FRAME_LEN);
    localparam logic [BCNT_W-1:0] MIN_CNT   = BCNT_W'(MIN_FRAME_LEN);
    localparam logic [7:0]        MIN_PRE   = 8'(MIN_PREAMBLE);

    rx_state_t              state_q;
    logic [7:0]             preCnt_q;
    logic [BCNT_W-1:0]      byteCnt_q;
    logic [FILL_W-1:0]      fill_q;
    logic [8*OUT_BYTES-1:0] word_q;
    logic                   err_q;
    logic                   giant_q;
    logic                   linkUp_q;
    eth_speed_t             speed_q;
    logic                   duplex_q;
    logic [8*OUT_BYTES-1:0] mData_q;
    logic [OUT_BYTES-1:0]   mKeep_q;
    logic                   mValid_q;
    logic                   mLast_q;
    logic                   mErr_q;
    logic [CNT_W-1:0]       cntOk_q;
    logic [CNT_W-1:0]       cntBad_q;

    logic [7:0] rxByte;
    logic       byteStb;
    logic       oddNibble;
    logic       crcBad;

    logic dataEnd;
    logic dataByte;
    logic giantHit;
    logic wordFull;
    logic emit;
    logic emitLast;
    logic emitErr;
    logic endErr;
    logic bumpOk;
    logic bumpBad;

    // speed_q only changes outside DATA, so the packer sees a frozen speed for the whole frame.
    rgmii_rx_nibble_pack uPack (
        .clk_125      (clk_125),
        .rst          (rst),
        .rx_data_i    (rx_data),
        .rx_dv_i      (rx_dv),
        .speed_i      (speed_q),
        .byte_o       (rxByte),
        .byte_stb_o   (byteStb),
        .odd_nibble_o (oddNibble)
    );

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q;

    // Running CRC over every DATA byte (FCS included), re-seeded whenever no frame is open.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            crc_q <= ETH_CRC_INIT;
        end else if (state_q != DATA) begin
            crc_q <= ETH_CRC_INIT;
        end else if (rx_dv && byteStb) begin
            crc_q <= crc32_byte(crc_q, rxByte);
        end
    end

    assign crcBad = (crc_q != ETH_CRC_RESIDUE);
`else
    assign crcBad = 1'b0;
`endif

    function automatic logic [OUT_BYTES-1:0] keepMask(input logic [FILL_W-1:0] fill);
        logic [OUT_BYTES-1:0] k;
        for (int i = 0; i < OUT_BYTES; i++) begin
            k[i] = (FILL_W'(i) < fill);
        end
        return k;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Decide this cycle's output word and counter events from the current state and byte strobe.
    always_comb begin
        dataEnd  = (state_q == DATA) && !rx_dv;
        dataByte = (state_q == DATA) && rx_dv && byteStb;
        giantHit = dataByte && (byteCnt_q == MAX_CNT);
        wordFull = (fill_q == FILL_FULL);
        endErr   = err_q | rx_er | oddNibble | (byteCnt_q < MIN_CNT) | crcBad;
        emitLast = (dataEnd && fill_q != '0) || giantHit;
        emit     = emitLast || (dataByte && wordFull);
        emitErr  = giantHit || (dataEnd && endErr);
        bumpOk   = emitLast && !emitErr;
        bumpBad  = (emitLast && emitErr)
                || (dataEnd && fill_q == '0)
                || (((state_q == PRE) || (state_q == DROP && !giant_q)) && !rx_dv && !rx_er);
    end

    // Receive FSM together with the word packer, registered outputs, status and counters.
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            preCnt_q  <= 8'h0;
            byteCnt_q <= '0;
            fill_q    <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            giant_q   <= 1'b0;
            linkUp_q  <= 1'b0;
            speed_q   <= SPEED_1G;
            duplex_q  <= 1'b0;
            mData_q   <= '0;
            mKeep_q   <= '0;
            mValid_q  <= 1'b0;
            mLast_q   <= 1'b0;
            mErr_q    <= 1'b0;
            cntOk_q   <= '0;
            cntBad_q  <= '0;
        end else begin
            mValid_q <= emit;
            mLast_q  <= emitLast;
            mErr_q   <= emitLast && emitErr;
            if (emit) begin
                mData_q <= word_q;
                mKeep_q <= keepMask(fill_q);
            end
            if (bumpOk) begin
                cntOk_q <= satInc(cntOk_q);
            end
            if (bumpBad) begin
                cntBad_q <= satInc(cntBad_q);
            end

            if (!rx_dv && !rx_er) begin
                linkUp_q <= rx_data[0];
                duplex_q <= rx_data[3];
                if (rx_data[2:1] != 2'b11 && state_q != DATA) begin
                    speed_q <= eth_speed_t'(rx_data[2:1]);
                end
            end

            case (state_q)
                IDLE: begin
                    if (byteStb) begin
                        if (rxByte == ETH_PREAMBLE) begin
                            state_q  <= PRE;
                            preCnt_q <= 8'h1;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (byteStb) begin
                        if (rxByte == ETH_PREAMBLE) begin
                            if (preCnt_q != 8'hFF) begin
                                preCnt_q <= preCnt_q + 8'h1;
                            end
                        end else if (rxByte == ETH_SFD && preCnt_q >= MIN_PRE) begin
                            state_q   <= DATA;
                            byteCnt_q <= '0;
                            fill_q    <= '0;
                            word_q    <= '0;
                            err_q     <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (!rx_dv && !rx_er) begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (dataEnd) begin
                        state_q <= IDLE;
                        fill_q  <= '0;
                    end else begin
                        if (rx_er) begin
                            err_q <= 1'b1;
                        end
                        if (giantHit) begin
                            state_q <= DROP;
                            giant_q <= 1'b1;
                            fill_q  <= '0;
                        end else if (dataByte) begin
                            byteCnt_q <= byteCnt_q + BCNT_W'(1);
                            if (wordFull) begin
                                word_q      <= '0;
                                word_q[7:0] <= rxByte;
                                fill_q      <= FILL_W'(1);
                            end else begin
                                for (int i = 0; i < OUT_BYTES; i++) begin
                                    if (fill_q == FILL_W'(i)) begin
                                        word_q[i*8 +: 8] <= rxByte;
                                    end
                                end
                                fill_q <= fill_q + FILL_W'(1);
                            end
                        end
                    end
                end
                DROP: begin
                    if (!rx_dv && !rx_er) begin
                        state_q <= IDLE;
                        giant_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m.m_data    = mData_q;
    assign m.m_keep    = mKeep_q;
    assign m.m_valid   = mValid_q;
    assign m.m_last    = mLast_q;
    assign m.m_err     = mErr_q;
    assign link_up     = linkUp_q;
    assign link_speed  = speed_q;
    assign full_duplex = duplex_q;
    assign cnt_ok      = cntOk_q;
    assign cnt_bad     = cntBad_q;

endmodule
